// File: rtl/cory_vr2sbd_arb.sv
// Round-robin adapter from N valid/ready requesters to one start/busy/done engine.
// Optional busy-cycle timeout is built when CORY_VR2SBD_ARB_TIMEOUT_EN is defined.
module cory_vr2sbd_arb #(
    parameter int N  = 2,
    parameter int W  = 8,
    parameter int CW = 1,
    parameter int TO = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   i_v,
    input  logic [N*W-1:0] i_d,
    output logic [N-1:0]   o_r,
    output logic           o_start,
    output logic           o_busy,
    output logic [CW-1:0]  o_ch,
    output logic [W-1:0]   o_d,
    input  logic           i_done,
    output logic           o_timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] ptr;
    logic [CW-1:0] grant;
    logic          grant_valid;
    logic          launch;
    logic          finish;
    logic          timeout_hit;
    int            off;
    int            best_off;

    if (N < 1 || (1 << CW) < N || TO < 1) begin : g_bad_cfg
        $error("cory_vr2sbd_arb: illegal N/CW/TO combination");
    end

    // Pick the requesting channel with the smallest distance from ptr, wrapping at N.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant       = '0;
        best_off    = N;
        off         = 0;
        for (int k = 0; k < N; k++) begin
            off = (k >= int'(ptr)) ? k - int'(ptr) : k + N - int'(ptr);
            if (i_v[k] && off < best_off) begin
                grant_valid = 1'b1;
                grant       = CW'(k);
                best_off    = off;
            end
        end
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: if (grant_valid) begin
                launch  = 1'b1;
                state_n = BUSY;
            end
            BUSY: if (i_done || timeout_hit) begin
                finish  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Ready is only ever raised for the granted channel in its completion cycle.
    always_comb begin
        o_r = '0;
        for (int k = 0; k < N; k++) begin
            o_r[k] = finish && (o_ch == CW'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the payload capture register is reset too, so o_d reads 0 after reset.
        if (!reset_n) begin
            o_start <= 1'b0;
            o_busy  <= 1'b0;
            o_ch    <= '0;
            o_d     <= '0;
            ptr     <= '0;
        end else begin
            o_start <= launch;
            if (launch) begin
                o_busy <= 1'b1;
                o_ch   <= grant;
                o_d    <= i_d[int'(grant)*W +: W];
            end else if (finish) begin
                o_busy <= 1'b0;
                ptr    <= (o_ch == CW'(N-1)) ? '0 : o_ch + 1'b1;
            end
        end
    end

`ifdef CORY_VR2SBD_ARB_TIMEOUT_EN
    localparam int TW = (TO > 1) ? $clog2(TO) : 1;

    logic [TW-1:0] cnt;

    // i_done in the limit cycle takes precedence over the forced completion.
    assign timeout_hit = (state == BUSY) && !i_done && (cnt == TW'(TO-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (launch)
                cnt <= '0;
            else if (state == BUSY && !i_done)
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cory_vr2sbd_arb.sv
// Self-checking bench for cory_vr2sbd_arb (N=4): expected grants are queued when
// requests are driven and popped when o_start is observed.
module tb_cory_vr2sbd_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   i_v;
    logic [N*W-1:0] i_d;
    logic [N-1:0]   o_r;
    logic           o_start;
    logic           o_busy;
    logic [CW-1:0]  o_ch;
    logic [W-1:0]   o_d;
    logic           i_done;
    logic           o_timeout;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [W-1:0]  d;
    } job_t;

    job_t sb[$];
    job_t exp_job;
    int   checks   = 0;
    int   failures = 0;

    cory_vr2sbd_arb #(.N(N), .W(W), .CW(CW), .TO(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_v       (i_v),
        .i_d       (i_d),
        .o_r       (o_r),
        .o_start   (o_start),
        .o_busy    (o_busy),
        .o_ch      (o_ch),
        .o_d       (o_d),
        .i_done    (i_done),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic s, input logic b, input logic [N-1:0] r);
        #1;
        check(tag, 32'({o_start, o_busy, o_r}), 32'({s, b, r}));
    endtask

    task automatic expect_grant(input int ch);
        job_t j;
        j.ch = CW'(ch);
        j.d  = i_d[ch*W +: W];
        sb.push_back(j);
    endtask

    // Scoreboard side: every start pulse must match the oldest queued grant.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && o_start === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_start", 32'd1, 32'd0);
            end else begin
                exp_job = sb.pop_front();
                check("grant_ch", 32'(o_ch), 32'(exp_job.ch));
                check("grant_d", 32'(o_d), 32'(exp_job.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        i_v     = '0;
        i_d     = '0;
        i_done  = 1'b0;
        repeat (3) tick();
        check_out("reset_out", 1'b0, 1'b0, 4'b0000);
        check("reset_ch_d", 32'({o_ch, o_d, o_timeout}), 32'd0);
        reset_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            tick();
            check_out("idle_out", 1'b0, 1'b0, 4'b0000);
            check("idle_ch_d", 32'({o_ch, o_d, o_timeout}), 32'd0);
        end

        // Single job on channel 0, payload change while busy must be ignored.
        i_d = 32'h4433_22A5;
        i_v = 4'b0001;
        expect_grant(0);
        check_out("req_cycle0", 1'b0, 1'b0, 4'b0000);
        tick();
        i_d = 32'h4433_225A;
        check_out("start_cycle1", 1'b1, 1'b1, 4'b0000);
        tick();
        check_out("busy_cycle2", 1'b0, 1'b1, 4'b0000);
        check("payload_frozen", 32'(o_d), 32'h0000_00A5);
        tick();
        i_done = 1'b1;
        check_out("done_cycle3", 1'b0, 1'b1, 4'b0001);
        tick();
        i_done = 1'b0;
        i_v    = '0;
        check_out("idle_cycle4", 1'b0, 1'b0, 4'b0000);

        // i_done while idle has no effect.
        i_done = 1'b1;
        check_out("done_in_idle", 1'b0, 1'b0, 4'b0000);
        tick();
        check_out("done_in_idle_next", 1'b0, 1'b0, 4'b0000);
        i_done = 1'b0;

        // Reset mid-job: ptr=1 so channel 2 wins, then the job is abandoned.
        i_d = 32'h4433_2211;
        i_v = 4'b0100;
        expect_grant(2);
        tick();
        check_out("rst_job_start", 1'b1, 1'b1, 4'b0000);
        tick();
        check_out("rst_job_busy", 1'b0, 1'b1, 4'b0000);
        check("rst_job_ch", 32'(o_ch), 32'd2);
        reset_n = 1'b0;
        i_done  = 1'b1;
        check_out("rst_mid_out", 1'b0, 1'b0, 4'b0000);
        check("rst_mid_ch_d", 32'({o_ch, o_d}), 32'd0);
        tick();
        reset_n = 1'b1;
        i_done  = 1'b0;
        i_v     = '0;
        check_out("rst_release", 1'b0, 1'b0, 4'b0000);

        // Fairness: all channels requesting, done every busy cycle, ptr restarts at 0.
        i_v    = 4'b1111;
        i_done = 1'b1;
        for (int j = 0; j < 5; j++) expect_grant(j % N);
        for (int j = 0; j < 5; j++) begin
            tick();
            check_out("rr_start", 1'b1, 1'b1, N'(1 << (j % N)));
            check("rr_ch", 32'(o_ch), 32'(j % N));
            tick();
            check_out("rr_gap", 1'b0, 1'b0, 4'b0000);
        end
        i_v    = '0;
        i_done = 1'b0;

        // Granted channel drops i_v while busy; channel 3 requests meanwhile.
        i_v = 4'b0010;
        expect_grant(1);
        tick();
        i_v = 4'b1000;
        check_out("viol_start", 1'b1, 1'b1, 4'b0000);
        tick();
        check_out("viol_busy", 1'b0, 1'b1, 4'b0000);
        tick();
        i_done = 1'b1;
        check_out("viol_done", 1'b0, 1'b1, 4'b0010);
        expect_grant(3);
        tick();
        i_done = 1'b0;
        check_out("late_req_idle", 1'b0, 1'b0, 4'b0000);
        tick();
        i_v = '0;
        check_out("late_req_start", 1'b1, 1'b1, 4'b0000);

`ifdef CORY_VR2SBD_ARB_TIMEOUT_EN
        // Channel 3 job: i_done held low, forced completion in the 4th busy cycle.
        tick();
        check_out("to_busy2", 1'b0, 1'b1, 4'b0000);
        tick();
        check_out("to_busy3", 1'b0, 1'b1, 4'b0000);
        tick();
        check_out("to_busy4_ready", 1'b0, 1'b1, 4'b1000);
        check("to_not_yet", 32'(o_timeout), 32'd0);
        tick();
        check_out("to_after", 1'b0, 1'b0, 4'b0000);
        check("to_pulse", 32'(o_timeout), 32'd1);
        tick();
        check("to_pulse_end", 32'(o_timeout), 32'd0);

        // ptr wrapped to 0; i_done arrives in the limit cycle and wins.
        i_v = 4'b0001;
        expect_grant(0);
        tick();
        i_v = '0;
        check_out("to2_start", 1'b1, 1'b1, 4'b0000);
        tick();
        tick();
        tick();
        i_done = 1'b1;
        check_out("to2_done_4th", 1'b0, 1'b1, 4'b0001);
        tick();
        i_done = 1'b0;
        check_out("to2_after", 1'b0, 1'b0, 4'b0000);
        check("to2_no_timeout", 32'(o_timeout), 32'd0);
`else
        // Without the timeout the engine may take as long as it likes.
        for (int c = 0; c < 8; c++) begin
            tick();
            check_out("long_wait", 1'b0, 1'b1, 4'b0000);
            check("long_wait_no_to", 32'(o_timeout), 32'd0);
        end
        i_done = 1'b1;
        check_out("long_done", 1'b0, 1'b1, 4'b1000);
        tick();
        i_done = 1'b0;
        check_out("long_after", 1'b0, 1'b0, 4'b0000);
`endif

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cory_vr2sbd_arb.md
# cory_vr2sbd_arb

N-channel adapter between valid/ready requesters and a single start/busy/done engine. Round-robin arbitration picks one pending channel, captures its payload and channel index, and pulses a one-cycle start. It then holds busy until the engine reports done. At that point the granted channel sees ready, completing its transfer. The block sits in front of a shared single-job engine that several valid/ready producers must use in turn.

## Interface
- N, 2, number of requesting channels (N >= 1)
- W, 8, payload width per channel
- CW, 1, channel index width; 2**CW >= N required
- TO, 255, busy-cycle limit before forced completion (used only with CORY_VR2SBD_ARB_TIMEOUT_EN; TO >= 1)

- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_v  input  N  per-channel request valid
- i_d  input  N*W  per-channel payload; channel k occupies bits [k*W +: W]
- o_r  output  N  per-channel ready, combinational
- o_start  output  1  one-cycle job start pulse, registered
- o_busy  output  1  engine job in progress, registered
- o_ch  output  CW  granted channel index, registered, stable while o_busy
- o_d  output  W  captured payload of granted channel, stable while o_busy
- i_done  input  1  engine job finished
- o_timeout  output  1  one-cycle pulse, forced completion by timeout

## Operation
- States: IDLE, BUSY. Internal regs: round-robin pointer ptr (CW bits), busy-cycle counter (timeout build only).
- Reset: state IDLE. o_start=0, o_busy=0, o_ch=0, o_d=0, o_timeout=0, ptr=0, counter=0. o_r=0.
- IDLE, no i_v bit set: state holds.
- IDLE, any i_v bit set: grant the first set channel searching ptr, ptr+1, ... N-1, 0, ... with wrap.
  - On the edge: o_ch <= grant, o_d <= i_d[grant], o_start <= 1, o_busy <= 1, state <= BUSY.
- BUSY: o_start returns to 0 after one cycle. o_ch and o_d stay frozen. Payload changes on i_d are ignored.
- BUSY with i_done=1: o_r[o_ch]=1 combinationally in that same cycle; all other o_r bits stay 0.
  - On the edge: state <= IDLE, o_busy <= 0, ptr <= (o_ch+1) wrapped at N.
- i_done is honoured in any BUSY cycle, including the o_start cycle.
- i_done in IDLE is ignored; o_r stays 0.
- o_r is 0 in every cycle except the completion cycle.
- Granted channel dropping i_v while BUSY is a protocol violation. The block still completes the job and pulses o_r.
- Non-granted channels may raise or drop i_v freely. A channel keeps its place only by holding i_v.
- N=1: o_ch is constant 0 and ptr is unused.

## Timing
- Request latency: i_v rises in IDLE cycle k -> o_start=1 and o_busy=1 in cycle k+1.
- Completion: i_done in cycle m (BUSY) -> o_r[ch]=1 in cycle m; o_busy=0 from cycle m+1.
- Back-to-back: the next grant is evaluated in cycle m+1 (IDLE), giving o_start in m+2.
- Peak rate: one job per 2 cycles.
- Fairness: with all N channels requesting continuously, each channel is granted once per N jobs.
- Reset asserted mid-job: immediate return to reset values; the in-flight job is abandoned with no o_r pulse.

## Configuration
- Macro: CORY_VR2SBD_ARB_TIMEOUT_EN.
- Defined:
  - The counter clears on entering BUSY and increments each BUSY cycle without i_done.
  - In the BUSY cycle where the counter equals TO-1 and i_done=0, the block forces completion:
    - o_r[o_ch]=1 in that cycle (combinational);
    - o_timeout <= 1 for one cycle, on the same edge that sets o_busy <= 0;
    - ptr advances as on normal completion.
  - If i_done arrives in that same cycle, normal completion wins and o_timeout stays 0.
- Undefined: no counter is built, o_timeout is tied 0, and BUSY waits for i_done indefinitely.

## Test plan
- Reset, then hold i_v=0 for 10 cycles -> all outputs 0, no o_start.
- N=2, W=8: i_v=2'b01, i_d[7:0]=0xA5 at cycle 0; i_done=1 at cycle 3.
  - o_start and o_busy high at cycle 1, o_ch=0, o_d=0xA5.
  - o_r=2'b01 only in cycle 3; o_busy=0 at cycle 4.
- N=4: all i_v held high, i_done=1 in every BUSY cycle -> o_ch sequence 0,1,2,3,0 with o_start every 2nd cycle.
- i_done=1 in the o_start cycle -> o_r pulses in that cycle; o_busy lasts exactly one cycle.
- reset_n dropped while o_busy=1 -> o_busy=0 and o_ch=0 immediately; no o_r pulse; after release the next grant starts from channel 0.
- With CORY_VR2SBD_ARB_TIMEOUT_EN, TO=4, i_done held 0:
  - o_r[ch] pulses in the 4th BUSY cycle; o_timeout=1 and o_busy=0 on the next cycle.
  - Repeat with i_done=1 in the 4th BUSY cycle -> o_timeout stays 0.
